// File: rtl/tt_check_pkg.sv
//==============================================================================
// Module     : tt_check_pkg
// Description: Shared types for the truth-table sweep checker.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

package tt_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit positions inside o_first_src
    localparam int C_SRC_A = 0;
    localparam int C_SRC_B = 1;

endpackage

`default_nettype wire

// File: rtl/tt_err_capture.sv
//==============================================================================
// Module     : tt_err_capture
// Description: Per-vector mismatch detect, saturating error count and
//              first-failure capture for the sweep checker.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tt_err_capture
    import tt_check_pkg::*;
#(
    parameter int IN_W  = 13,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [IN_W-1:0]  vec_i,
    input  logic [OUT_W-1:0] exp_i,
    input  logic [OUT_W-1:0] y_a_i,
    input  logic [OUT_W-1:0] y_b_i,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [IN_W-1:0]  first_vec_o,
    output logic [1:0]       first_src_o,
    output logic [OUT_W-1:0] first_exp_o
);

    logic             w_mis_a;
    logic             w_mis_b;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [IN_W-1:0]  first_vec_q, first_vec_d;
    logic [1:0]       first_src_q, first_src_d;
    logic [OUT_W-1:0] first_exp_q, first_exp_d;

    assign w_mis_a    = (y_a_i != exp_i);
    assign w_mis_b    = (y_b_i != exp_i);
    assign mismatch_o = w_mis_a | w_mis_b;

    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_vec_d = first_vec_q;
        first_src_d = first_src_q;
        first_exp_d = first_exp_q;
        if (clear_i) begin
            err_cnt_d   = '0;
            first_vec_d = '0;
            first_src_d = '0;
            first_exp_d = '0;
        end else if (en_i && mismatch_o) begin
            if (err_cnt_q == '0) begin
                first_vec_d          = vec_i;
                first_src_d[C_SRC_A] = w_mis_a;
                first_src_d[C_SRC_B] = w_mis_b;
                first_exp_d          = exp_i;
            end
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= '0;
            first_vec_q <= '0;
            first_src_q <= '0;
            first_exp_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_vec_q <= first_vec_d;
            first_src_q <= first_src_d;
            first_exp_q <= first_exp_d;
        end
    end

    assign err_cnt_o   = err_cnt_q;
    assign first_vec_o = first_vec_q;
    assign first_src_o = first_src_q;
    assign first_exp_o = first_exp_q;

endmodule

`default_nettype wire

// File: rtl/tt_sweep_checker.sv
//==============================================================================
// Module     : tt_sweep_checker
// Description: Exhaustive input sweep comparing two truth-table DUTs against
//              an expected-value table memory.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int IN_W   = 13,
    parameter int OUT_W  = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_stop_on_err,
    output logic [IN_W-1:0]  o_x,
    output logic [IN_W-1:0]  o_addr,
    input  logic [OUT_W-1:0] i_exp,
    input  logic [OUT_W-1:0] i_y_a,
    input  logic [OUT_W-1:0] i_y_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [IN_W-1:0]  o_first_vec,
    output logic [1:0]       o_first_src,
    output logic [OUT_W-1:0] o_first_exp
);

    localparam int                 WAIT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0]  C_WAIT_LAST = WAIT_W'(SETTLE - 1);
    localparam logic [IN_W-1:0]    C_VEC_LAST  = '1;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   vec_q,   vec_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic              stop_q,  stop_d;
    logic              w_start;
    logic              w_check;
    logic              w_mismatch;

    assign w_start = i_start && !i_abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign w_check = (state_q == ST_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        stop_d  = stop_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_d = ST_DRIVE;
                        vec_d   = '0;
                        stop_d  = i_stop_on_err;
                    end
                end
                ST_DRIVE: begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end
                ST_WAIT: begin
                    if (wait_q == C_WAIT_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // The counter never advances past all-ones, so the sweep cannot wrap
                    if ((stop_q && w_mismatch) || vec_q == C_VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                        vec_d   = vec_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_x    = vec_q;
        o_addr = vec_q;
        o_busy = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
        o_done = (state_q == ST_DONE);
        o_pass = (state_q == ST_DONE) && (o_err_cnt == '0);
    end

    tt_err_capture #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (w_start),
        .en_i        (w_check),
        .vec_i       (vec_q),
        .exp_i       (i_exp),
        .y_a_i       (i_y_a),
        .y_b_i       (i_y_b),
        .mismatch_o  (w_mismatch),
        .err_cnt_o   (o_err_cnt),
        .first_vec_o (o_first_vec),
        .first_src_o (o_first_src),
        .first_exp_o (o_first_exp)
    );

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
//==============================================================================
// Module     : tb_tt_sweep_checker
// Description: Scoreboard bench for tt_sweep_checker with a 4-in/2-out table.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tt_sweep_checker;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 2;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 3;
    localparam int NV     = 1 << IN_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_stop_on_err = 1'b0;
    logic [IN_W-1:0]  o_x, o_addr;
    logic [OUT_W-1:0] i_exp, i_y_a, i_y_b;
    logic             o_busy, o_done, o_pass;
    logic [CNT_W-1:0] o_err_cnt;
    logic [IN_W-1:0]  o_first_vec;
    logic [1:0]       o_first_src;
    logic [OUT_W-1:0] o_first_exp;

    logic [NV-1:0]    fa = '0;
    logic [NV-1:0]    fb = '0;
    logic [OUT_W-1:0] flip_a = 2'd1;
    logic [OUT_W-1:0] flip_b = 2'd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit pass;
        int err;
        int fvec;
        int fsrc;
        int fexp;
        int last;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t sb[$];

    tt_sweep_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_stop_on_err(i_stop_on_err), .o_x(o_x), .o_addr(o_addr),
        .i_exp(i_exp), .i_y_a(i_y_a), .i_y_b(i_y_b), .o_busy(o_busy),
        .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
        .o_first_vec(o_first_vec), .o_first_src(o_first_src),
        .o_first_exp(o_first_exp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table memory holds f(x) = x[1:0] with one cycle of read latency
    always @(posedge clk) i_exp <= o_addr[OUT_W-1:0];

    always_comb begin
        i_y_a = o_x[OUT_W-1:0] ^ (fa[o_x] ? flip_a : '0);
        i_y_b = o_x[OUT_W-1:0] ^ (fb[o_x] ? flip_b : '0);
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [NV-1:0] fa_m, input logic [NV-1:0] fb_m,
                                   input bit stop, input int start_c);
        exp_t e;
        e.err = 0; e.fvec = 0; e.fsrc = 0; e.fexp = 0;
        e.last = NV - 1; e.start_cyc = start_c;
        for (int v = 0; v < NV; v++) begin
            if (fa_m[v] || fb_m[v]) begin
                if (e.err == 0) begin
                    e.fvec = v;
                    e.fsrc = (fb_m[v] ? 2 : 0) + (fa_m[v] ? 1 : 0);
                    e.fexp = v % (1 << OUT_W);
                end
                if (e.err < CMAX) e.err++;
                if (stop) begin
                    e.last = v;
                    break;
                end
            end
        end
        e.pass = (e.err == 0);
        e.lat  = (SETTLE + 2) * (e.last + 1) + 1;
        return e;
    endfunction

    // Monitor: score every completed sweep against the queued expectation
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && o_done && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pass",      int'(o_pass),      int'(e.pass));
                chk("err_cnt",   int'(o_err_cnt),   e.err);
                chk("first_vec", int'(o_first_vec), e.fvec);
                chk("first_src", int'(o_first_src), e.fsrc);
                chk("first_exp", int'(o_first_exp), e.fexp);
                chk("final_x",   int'(o_x),         e.last);
                chk("latency",   cyc - e.start_cyc + 1, e.lat);
            end
        end
        prev_done = o_done;
    end

    task automatic run_sweep(input logic [NV-1:0] fa_v, input logic [NV-1:0] fb_v,
                             input bit stop, input bit poke);
        exp_t e;
        int n;
        @(negedge clk);
        fa = fa_v;
        fb = fb_v;
        i_stop_on_err = stop;
        i_start = 1'b1;
        e = model(fa_v, fb_v, stop, cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        if (poke && e.last >= 5) begin
            repeat ($urandom_range(2, 10)) @(negedge clk);
            i_start = 1'b1;
            i_stop_on_err = ~stop;
            @(negedge clk);
            i_start = 1'b0;
        end
        n = 0;
        while (!o_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) chk("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        chk("hold_done", int'(o_done), 1);
        chk("hold_x",    int'(o_x),    e.last);
    endtask

    task automatic wait_vec(input int v);
        int n = 0;
        while (o_x != IN_W'(v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (o_x != IN_W'(v)) chk("wait_vec_timeout", int'(o_x), v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_pass", int'(o_pass), 0);
        chk("rst_x",    int'(o_x),    0);
        chk("rst_cnt",  int'(o_err_cnt), 0);
        chk("rst_src",  int'(o_first_src), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(16'h0000, 16'h0000, 1'b0, 1'b0);
        run_sweep(16'h0000, 16'h0400, 1'b0, 1'b0);
        run_sweep(16'h0208, 16'h0008, 1'b1, 1'b0);
        run_sweep(16'h8000, 16'h0000, 1'b0, 1'b0);
        run_sweep(16'hFFFF, 16'h0000, 1'b0, 1'b1);

        // Abort mid-sweep: results kept, status cleared
        @(negedge clk);
        fa = '0;
        fb = 16'h0004;
        i_stop_on_err = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_vec(5);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        chk("abort_pass", int'(o_pass), 0);
        chk("abort_cnt",  int'(o_err_cnt), 1);
        chk("abort_vec",  int'(o_first_vec), 2);
        chk("abort_src",  int'(o_first_src), 2);

        // Asynchronous reset mid-sweep
        fa = 16'h0002;
        fb = '0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_vec(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_x",    int'(o_x),    0);
        chk("arst_addr", int'(o_addr), 0);
        chk("arst_cnt",  int'(o_err_cnt), 0);
        chk("arst_vec",  int'(o_first_vec), 0);
        chk("arst_src",  int'(o_first_src), 0);
        chk("arst_exp",  int'(o_first_exp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            flip_a = OUT_W'($urandom_range(1, 3));
            flip_b = OUT_W'($urandom_range(1, 3));
            run_sweep(NV'($urandom & $urandom & $urandom),
                      NV'($urandom & $urandom & $urandom),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
